// File: rtl/axi4_sram_slave.sv
// AXI4 slave in front of a word-addressed on-chip SRAM.
// Independent write and read FSMs, FIXED/INCR bursts, byte strobes, SLVERR on bad beats.
module axi4_sram_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int         IDX_W       = $clog2(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (off >> (IDX_W + 2)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic is_legal(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b00 || burst == 2'b01) && size == 3'b010;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] burst);
    return (burst == 2'b01) ? a + ADDR_WIDTH'(4) : a;
  endfunction

  // ---------------- write side ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_legal_q, w_legal_d, w_err_q, w_err_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  w_we, w_beat_ok, w_err_nxt;

  // NOTE: every variable gets its default at the top of always_comb so no path infers a latch.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_legal_d = w_legal_q;
    w_err_d   = w_err_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    w_we      = 1'b0;
    w_beat_ok = 1'b0;
    w_err_nxt = w_err_q;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          w_id_d    = s_axi_awid;
          w_addr_d  = s_axi_awaddr;
          w_cnt_d   = s_axi_awlen;
          w_burst_d = s_axi_awburst;
          w_legal_d = is_legal(s_axi_awburst, s_axi_awsize);
          w_err_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          w_beat_ok = w_legal_q && in_range(w_addr_q);
          w_we      = w_beat_ok;
          // Count terminates the burst; a wlast in the wrong place only flags an error.
          w_err_nxt = w_err_q || !w_beat_ok || (s_axi_wlast != (w_cnt_q == 8'd0));
          w_err_d   = w_err_nxt;
          if (w_cnt_q == 8'd0) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = w_id_q;
            bresp_d   = w_err_nxt ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end else begin
            w_addr_d = next_addr(w_addr_q, w_burst_q);
            w_cnt_d  = w_cnt_q - 8'd1;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_legal_q <= 1'b0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_legal_q <= w_legal_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // NOTE: the SRAM array has no reset; it maps to a RAM macro and its contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (s_axi_wstrb[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read side ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic                  r_legal_q, r_legal_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rd_load, rd_legal, rd_ok;
  logic [ADDR_WIDTH-1:0] rd_addr;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    r_addr_d  = r_addr_q;
    r_cnt_d   = r_cnt_q;
    r_burst_d = r_burst_q;
    r_legal_d = r_legal_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_load   = 1'b0;
    rd_legal  = r_legal_q;
    rd_addr   = r_addr_q;
    rd_ok     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          rid_d     = s_axi_arid;
          r_addr_d  = s_axi_araddr;
          r_cnt_d   = s_axi_arlen;
          r_burst_d = s_axi_arburst;
          r_legal_d = is_legal(s_axi_arburst, s_axi_arsize);
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (s_axi_arlen == 8'd0);
          rd_load   = 1'b1;
          rd_legal  = r_legal_d;
          rd_addr   = s_axi_araddr;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready && rvalid_q) begin
          if (r_cnt_q == 8'd0) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            // Next beat is fetched on the accepting edge so back-to-back beats have no bubble.
            r_addr_d = next_addr(r_addr_q, r_burst_q);
            r_cnt_d  = r_cnt_q - 8'd1;
            rlast_d  = (r_cnt_q == 8'd1);
            rd_load  = 1'b1;
            rd_addr  = r_addr_d;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (rd_load) begin
      rd_ok   = rd_legal && in_range(rd_addr);
      rdata_d = rd_ok ? mem[word_idx(rd_addr)] : '0;
      rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      r_addr_q  <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      r_legal_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      r_addr_q  <= r_addr_d;
      r_cnt_q   <= r_cnt_d;
      r_burst_q <= r_burst_d;
      r_legal_q <= r_legal_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Self-checking bench for axi4_sram_slave: directed cases plus random bursts
// compared against an array-based memory model.
module tb_axi4_sram_slave;

  localparam int          MEM_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h0000_0000;

  logic        aclk, aresetn;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  axi4_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4),
                    .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] model [MEM_WORDS];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  logic [3:0]  rd_id [256];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_in_range(input logic [31:0] a);
    return (a - BASE) < 32'(MEM_WORDS * 4);
  endfunction
  function automatic bit m_legal(input logic [1:0] burst, input logic [2:0] size);
    return burst < 2'd2 && size == 3'd2;
  endfunction
  function automatic logic [31:0] m_beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
    return (burst == 2'b01) ? a + 32'(4 * i) : a;
  endfunction
  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, input int nbeats, input int bad_last,
                             output logic [1:0] exp_resp);
    bit err;
    logic [31:0] a;
    err = !m_legal(burst, size) || (bad_last >= 0 && bad_last <= len);
    for (int i = 0; i < nbeats; i++) begin
      a = m_beat_addr(addr, burst, i);
      if (m_legal(burst, size) && m_in_range(a)) begin
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) model[m_idx(a)][8*b +: 8] = wd[i][8*b +: 8];
      end else err = 1'b1;
    end
    exp_resp = err ? 2'b10 : 2'b00;
  endtask

  // ---------------- bus drivers (all start and end 1 ns after a rising edge) ----------------
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int bdelay,
                          input int bad_last, output logic [3:0] bid_o, output logic [1:0] bresp_o,
                          output int lat);
    int beat, cyc, aw_cyc, b_cyc;
    bit hs_aw, hs_w;
    beat = 0; cyc = 0; aw_cyc = 0; b_cyc = -1;
    awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size; awvalid = 1'b1;
    wdata = wd[0]; wstrb = ws[0]; wlast = (len == 0) ^ (bad_last == 0); wvalid = 1'b1;
    bready = 1'b0;
    while (b_cyc < 0 && cyc < 3000) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge aclk); #1; cyc++;
      if (hs_aw) begin awvalid = 1'b0; aw_cyc = cyc; end
      if (hs_w) begin
        beat++;
        if (beat > len) wvalid = 1'b0;
        else begin
          wdata = wd[beat]; wstrb = ws[beat]; wlast = (beat == len) ^ (beat == bad_last);
        end
      end
      if (bvalid) b_cyc = cyc;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("b_timeout", 64'(b_cyc < 0), 64'(0));
    lat = b_cyc + 1 - aw_cyc;
    for (int k = 0; k < bdelay; k++) begin
      @(posedge aclk); #1;
      check("b_hold_valid", 64'(bvalid), 64'(1));
      check("b_hold_awready", 64'(awready), 64'(0));
    end
    bid_o = bid; bresp_o = bresp;
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("b_drop", 64'(bvalid), 64'(0));
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size, input bit toggle,
                         output int lat);
    int nb, cyc, ar_cyc, r_cyc;
    bit hs_ar, hs_r, stall;
    logic [35:0] snap;
    nb = 0; cyc = 0; ar_cyc = 0; r_cyc = -1;
    arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arsize = size; arvalid = 1'b1;
    rready = 1'b1;
    while (nb <= len && cyc < 3000) begin
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      stall = rvalid && !rready;
      snap  = {rlast, rresp, rdata, rvalid};
      if (hs_r && nb < 256) begin
        rd_data[nb] = rdata; rd_resp[nb] = rresp; rd_last[nb] = rlast; rd_id[nb] = rid;
      end
      @(posedge aclk); #1; cyc++;
      if (hs_ar) begin arvalid = 1'b0; ar_cyc = cyc; end
      if (hs_r) nb++;
      if (stall) check("r_stall_stable", 64'({rlast, rresp, rdata, rvalid}), 64'(snap));
      if (r_cyc < 0 && rvalid) r_cyc = cyc;
      if (toggle) rready = !rready;
    end
    arvalid = 1'b0; rready = 1'b0;
    check("r_beats", 64'(nb), 64'(len + 1));
    check("r_done_valid", 64'(rvalid), 64'(0));
    lat = r_cyc + 1 - ar_cyc;
  endtask

  task automatic compare_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                              input int len, input logic [1:0] burst, input logic [2:0] size);
    logic [31:0] a;
    bit ok;
    for (int i = 0; i <= len; i++) begin
      a  = m_beat_addr(addr, burst, i);
      ok = m_legal(burst, size) && m_in_range(a);
      check({tag, "_data"}, 64'(rd_data[i]), ok ? 64'(model[m_idx(a)]) : 64'(0));
      check({tag, "_resp"}, 64'(rd_resp[i]), ok ? 64'(0) : 64'(2));
      check({tag, "_last"}, 64'(rd_last[i]), 64'(i == len));
      check({tag, "_id"}, 64'(rd_id[i]), 64'(id));
    end
  endtask

  task automatic write_check(input string tag, input logic [3:0] id, input logic [31:0] addr,
                             input int len, input logic [1:0] burst, input logic [2:0] size,
                             input int bdelay, input int bad_last);
    logic [3:0] g_bid;
    logic [1:0] g_resp, e_resp;
    int lat;
    do_write(id, addr, len, burst, size, bdelay, bad_last, g_bid, g_resp, lat);
    model_write(addr, len, burst, size, len + 1, bad_last, e_resp);
    check({tag, "_bid"}, 64'(g_bid), 64'(id));
    check({tag, "_bresp"}, 64'(g_resp), 64'(e_resp));
  endtask

  task automatic read_check(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input int len, input logic [1:0] burst, input logic [2:0] size,
                            input bit toggle);
    int lat;
    do_read(id, addr, len, burst, size, toggle, lat);
    compare_read(tag, id, addr, len, burst, size);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  g_bid;
    logic [1:0]  g_resp, e_resp;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [2:0]  size;
    int lat, len, sel, acc, cyc;
    bit hs_aw, hs_w;

    aresetn = 1'b0;
    {awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready} = '0;
    {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
    #23;
    check("reset_outputs", 64'({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast}), 64'(0));
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("post_reset_awready", 64'(awready), 64'(1));
    check("post_reset_arready", 64'(arready), 64'(1));

    // Fill the whole SRAM with known random data using maximum-length bursts.
    for (int blk = 0; blk < MEM_WORDS / 256; blk++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      write_check("fill", 4'(blk), BASE + 32'(blk * 1024), 255, 2'b01, 3'd2, 0, -1);
    end

    // Single access with latency checks.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(4'd2, BASE + 32'h10, 0, 2'b01, 3'd2, 0, -1, g_bid, g_resp, lat);
    model_write(BASE + 32'h10, 0, 2'b01, 3'd2, 1, -1, e_resp);
    check("single_bvalid_latency", 64'(lat), 64'(2));
    check("single_bid", 64'(g_bid), 64'(2));
    check("single_bresp", 64'(g_resp), 64'(0));
    do_read(4'd1, BASE + 32'h10, 0, 2'b01, 3'd2, 1'b0, lat);
    check("single_rvalid_latency", 64'(lat), 64'(1));
    check("single_rdata", 64'(rd_data[0]), 64'(32'hDEADBEEF));
    check("single_rid", 64'(rd_id[0]), 64'(1));
    check("single_rlast", 64'(rd_last[0]), 64'(1));
    check("single_rresp", 64'(rd_resp[0]), 64'(0));

    // Byte strobes.
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    write_check("strobe", 4'd3, BASE + 32'h10, 0, 2'b01, 3'd2, 0, -1);
    read_check("strobe_rd", 4'd3, BASE + 32'h10, 0, 2'b01, 3'd2, 1'b0);
    check("strobe_literal", 64'(rd_data[0]), 64'(32'hDE22BE44));

    // INCR burst, read back with rready toggling every cycle.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    write_check("incr", 4'd4, BASE + 32'h20, 3, 2'b01, 3'd2, 0, -1);
    read_check("incr_rd", 4'd5, BASE + 32'h20, 3, 2'b01, 3'd2, 1'b1);
    check("incr_beat3_literal", 64'(rd_data[2]), 64'(3));

    // FIXED burst keeps overwriting one word.
    wd[0] = 32'hA; wd[1] = 32'hB; ws[0] = 4'hF; ws[1] = 4'hF;
    write_check("fixed", 4'd6, BASE + 32'h30, 1, 2'b00, 3'd2, 0, -1);
    read_check("fixed_rd", 4'd6, BASE + 32'h30, 0, 2'b01, 3'd2, 1'b0);
    check("fixed_literal", 64'(rd_data[0]), 64'(32'hB));

    // Out of range, illegal burst type, misplaced wlast, long bready stall.
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    write_check("oor", 4'd7, BASE + 32'(4 * MEM_WORDS), 0, 2'b01, 3'd2, 5, -1);
    read_check("oor_rd", 4'd7, BASE + 32'(4 * MEM_WORDS), 0, 2'b01, 3'd2, 1'b0);
    read_check("alias_word0", 4'd7, BASE, 0, 2'b01, 3'd2, 1'b0);
    write_check("wrap_burst", 4'd8, BASE + 32'h40, 0, 2'b10, 3'd2, 0, -1);
    read_check("wrap_burst_rd", 4'd8, BASE + 32'h40, 0, 2'b10, 3'd2, 1'b0);
    read_check("wrap_after", 4'd8, BASE + 32'h40, 0, 2'b01, 3'd2, 1'b0);
    wd[0] = 32'h5; wd[1] = 32'h6; ws[1] = 4'hF;
    write_check("bad_wlast", 4'd9, BASE + 32'h50, 1, 2'b01, 3'd2, 0, 0);
    read_check("bad_wlast_rd", 4'd9, BASE + 32'h50, 1, 2'b01, 3'd2, 1'b0);

    // Random traffic, including bursts that run off the end of the array.
    for (int t = 0; t < 40; t++) begin
      len   = $urandom_range(0, 15);
      sel   = $urandom_range(0, 9);
      addr  = BASE + 32'($urandom_range(0, MEM_WORDS - 1) * 4) + 32'($urandom_range(0, 3));
      burst = (sel == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      size  = (sel == 1) ? 3'($urandom_range(0, 1)) : 3'd2;
      if (sel == 2) begin addr = BASE + 32'((MEM_WORDS - 4) * 4); burst = 2'b01; end
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      write_check("rand_wr", 4'($urandom), addr, len, burst, size, $urandom_range(0, 3), -1);
      read_check("rand_rd", 4'($urandom), addr, len, 2'b01, 3'd2, 1'($urandom));
    end

    // Reset in the middle of an INCR len=7 write after three beats were accepted.
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h7700_0000 + 32'(i); ws[i] = 4'hF; end
    awid = 4'd1; awaddr = BASE + 32'h200; awlen = 8'd7; awburst = 2'b01; awsize = 3'd2;
    awvalid = 1'b1; wdata = wd[0]; wstrb = ws[0]; wlast = 1'b0; wvalid = 1'b1; bready = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 3 && cyc < 50) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge aclk); #1; cyc++;
      if (hs_aw) awvalid = 1'b0;
      if (hs_w) begin acc++; wdata = wd[acc]; wstrb = ws[acc]; end
    end
    check("rst_beats_before_reset", 64'(acc), 64'(3));
    aresetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    #1;
    check("rst_outputs_zero", 64'({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast}), 64'(0));
    #20;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("rst_release_awready", 64'(awready), 64'(1));
    check("rst_release_arready", 64'(arready), 64'(1));
    model_write(BASE + 32'h200, 7, 2'b01, 3'd2, acc, -1, e_resp);
    read_check("rst_rd", 4'd2, BASE + 32'h200, 7, 2'b01, 3'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
